ram_kex_pingpong: RTL and testbench

//  Double-buffered (ping-pong) kernel tile store for the 1*1 expansion convolution.
//  The loader fills one bank with the next kernel tile while the datapath reads the

---
 rtl/ram_kex_pingpong_pkg.sv | 25 ++
 rtl/ram_kex_pingpong_if.sv | 42 ++++
 rtl/ram_kex_pingpong_bank.sv | 37 +++
 rtl/ram_kex_pingpong.sv | 186 ++++++++++++++++++
 tb/tb_ram_kex_pingpong.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_kex_pingpong_pkg.sv
// Shared types and sizing for the ping-pong kernel tile store of the
// 1x1 expansion convolution.
package ram_kex_pingpong_pkg;

    localparam int WG_W       = 8;
    localparam int NPAR       = 8;
    localparam int KEX_N_ELEM = 24;

    localparam int KEX_ADDR_W = $clog2(KEX_N_ELEM);
    localparam int KEX_DATA_W = WG_W + $clog2(NPAR + 1);

    typedef logic [KEX_DATA_W-1:0] kex_word_t;

    // Bit positions inside the sticky err vector.
    typedef enum logic [0:0] {
        ERR_WR = 1'b0,
        ERR_RD = 1'b1
    } kex_err_e;

    // Even parity bit for a stored word: XOR of all data bits.
    function automatic logic even_parity(input kex_word_t w);
        return ^w;
    endfunction

endpackage

// File: rtl/ram_kex_pingpong_if.sv
// Loader/consumer bus of the kernel tile store.
// With KRAM_PARITY_EN defined the bus also carries err_parity.
interface ram_kex_pingpong_if
    import ram_kex_pingpong_pkg::*;
;
    // Fill side (DRAM loader)
    logic                  wr_en;
    logic [KEX_ADDR_W-1:0] wr_addr;
    kex_word_t             wr_data;
    logic                  wr_last;
    logic                  fill_ready;

    // Read side (expansion MAC array)
    logic                  rd_en;
    logic [KEX_ADDR_W-1:0] rd_addr;
    logic                  rd_done;
    logic                  tile_avail;
    kex_word_t             rd_data;
    logic                  rd_valid;

    logic [1:0]            err;
`ifdef KRAM_PARITY_EN
    logic                  err_parity;
`endif

    modport master (
        output wr_en, wr_addr, wr_data, wr_last, rd_en, rd_addr, rd_done,
        input  fill_ready, tile_avail, rd_data, rd_valid, err
`ifdef KRAM_PARITY_EN
        , input err_parity
`endif
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_last, rd_en, rd_addr, rd_done,
        output fill_ready, tile_avail, rd_data, rd_valid, err
`ifdef KRAM_PARITY_EN
        , output err_parity
`endif
    );

endinterface

// File: rtl/ram_kex_pingpong_bank.sv
// One kernel tile bank: simple dual-port RAM, one write port and one
// registered read port, written so that it maps onto block RAM.
module ram_kex_bank #(
    parameter  int WIDTH  = 12,
    parameter  int DEPTH  = 24,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Write port and registered read port; the read register only moves on
    // an accepted read so the last word stays on o_rdata.
    // NOTE: no reset here on purpose -- a reset on the array or its read
    // register would stop block-RAM inference; the top masks stale output.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all clocked state, so every
        // register samples pre-edge values regardless of statement order.
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_kex_pingpong.sv
// Double-buffered kernel tile store: the loader fills one bank while the
// MAC array reads the other. Tracks tile ownership (wb/rb/cnt), offers a
// read latency of 1 or 2 cycles and keeps sticky error flags.
// Optional feature: KRAM_PARITY_EN adds a stored even-parity bit per word
// and the sticky err_parity output.
module ram_kex_pingpong
    import ram_kex_pingpong_pkg::*;
#(
    parameter  int DATA_W = KEX_DATA_W,
    parameter  int DEPTH  = KEX_N_ELEM,
    parameter  int RD_LAT = 1,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    ram_kex_pingpong_if.slave  io_kex
);

`ifdef KRAM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    // Addresses are compared one bit wider so DEPTH itself is representable.
    localparam logic [ADDR_W:0] ADDR_LIM = (ADDR_W + 1)'(DEPTH);

    logic             r_wb;
    logic             r_rb;
    logic [1:0]       r_cnt;
    logic [1:0]       r_err;
    logic             r_v1;
    logic             r_sel1;

    logic             w_fill_ready;
    logic             w_tile_avail;
    logic             w_wr_acc;
    logic             w_wr_rej;
    logic             w_last_acc;
    logic             w_rd_acc;
    logic             w_rd_rej;
    logic             w_done_acc;
    logic [1:0]       w_cnt_nxt;
    logic [MEM_W-1:0] w_wr_word;
    logic [MEM_W-1:0] w_q0;
    logic [MEM_W-1:0] w_q1;
    logic [MEM_W-1:0] w_s1_word;
    logic [MEM_W-1:0] w_out_word;
    logic             w_out_valid;

    assign w_fill_ready = (r_cnt != 2'd2);
    assign w_tile_avail = (r_cnt != 2'd0);

    assign w_wr_acc   = io_kex.wr_en & w_fill_ready & ({1'b0, io_kex.wr_addr} < ADDR_LIM);
    assign w_wr_rej   = io_kex.wr_en & ~w_wr_acc;
    assign w_last_acc = w_wr_acc & io_kex.wr_last;
    assign w_rd_acc   = io_kex.rd_en & w_tile_avail & ({1'b0, io_kex.rd_addr} < ADDR_LIM);
    assign w_rd_rej   = io_kex.rd_en & ~w_rd_acc;
    assign w_done_acc = io_kex.rd_done & w_tile_avail;

    // Tiles-held count: a completed fill and a release in the same cycle cancel.
    always_comb begin
        // NOTE: default first so every path assigns w_cnt_nxt and no latch is inferred.
        w_cnt_nxt = r_cnt;
        case ({w_last_acc, w_done_acc})
            2'b10:   w_cnt_nxt = r_cnt + 2'd1;
            2'b01:   w_cnt_nxt = r_cnt - 2'd1;
            default: ;
        endcase
    end

    // Bank ownership, tile count and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb  <= 1'b0;
            r_rb  <= 1'b0;
            r_cnt <= 2'd0;
            r_err <= 2'b00;
        end else begin
            if (w_last_acc) r_wb <= ~r_wb;
            if (w_done_acc) r_rb <= ~r_rb;
            r_cnt <= w_cnt_nxt;
            if (w_wr_rej) r_err[ERR_WR] <= 1'b1;
            if (w_rd_rej) r_err[ERR_RD] <= 1'b1;
        end
    end

    // First read stage: remember which bank answers and whether a word is due.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_sel1 <= 1'b0;
        end else begin
            r_v1 <= w_rd_acc;
            if (w_rd_acc) r_sel1 <= r_rb;
        end
    end

`ifdef KRAM_PARITY_EN
    assign w_wr_word = {even_parity(io_kex.wr_data), io_kex.wr_data};
`else
    assign w_wr_word = io_kex.wr_data;
`endif

    ram_kex_bank #(.WIDTH(MEM_W), .DEPTH(DEPTH)) u_bank0 (
        .clk     (clk),
        .i_we    (w_wr_acc & ~r_wb),
        .i_waddr (io_kex.wr_addr),
        .i_wdata (w_wr_word),
        .i_re    (w_rd_acc & ~r_rb),
        .i_raddr (io_kex.rd_addr),
        .o_rdata (w_q0)
    );

    ram_kex_bank #(.WIDTH(MEM_W), .DEPTH(DEPTH)) u_bank1 (
        .clk     (clk),
        .i_we    (w_wr_acc & r_wb),
        .i_waddr (io_kex.wr_addr),
        .i_wdata (w_wr_word),
        .i_re    (w_rd_acc & r_rb),
        .i_raddr (io_kex.rd_addr),
        .o_rdata (w_q1)
    );

    assign w_s1_word = r_sel1 ? w_q1 : w_q0;

    if (RD_LAT == 2) begin : g_lat2
        logic             r_v2;
        logic [MEM_W-1:0] r_word2;

        // Second read stage; holds the last delivered word between reads.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_v2    <= 1'b0;
                r_word2 <= '0;
            end else begin
                r_v2 <= r_v1;
                if (r_v1) r_word2 <= w_s1_word;
            end
        end

        assign w_out_valid = r_v2;
        assign w_out_word  = r_word2;
    end else begin : g_lat1
        logic r_loaded;

        // Bank registers are unreset, so rd_data reads zero until the first
        // accepted read after reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_loaded <= 1'b0;
            end else if (w_rd_acc) begin
                r_loaded <= 1'b1;
            end
        end

        assign w_out_valid = r_v1;
        assign w_out_word  = r_loaded ? w_s1_word : '0;
    end

`ifdef KRAM_PARITY_EN
    logic r_err_parity;
    logic w_par_err;

    // A stored word plus its even-parity bit must XOR to zero.
    assign w_par_err = w_out_valid & (^w_out_word);

    // Sticky parity flag; the live term makes it visible with rd_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_parity <= 1'b0;
        end else if (w_par_err) begin
            r_err_parity <= 1'b1;
        end
    end

    assign io_kex.err_parity = r_err_parity | w_par_err;
`endif

    assign io_kex.fill_ready = w_fill_ready;
    assign io_kex.tile_avail = w_tile_avail;
    assign io_kex.rd_data    = w_out_word[DATA_W-1:0];
    assign io_kex.rd_valid   = w_out_valid;
    assign io_kex.err        = r_err;

endmodule

// File: tb/tb_ram_kex_pingpong.sv
// Bench for ram_kex_pingpong: one instance with RD_LAT=1 and one with
// RD_LAT=2 share the same stimulus and are checked every cycle against a
// tile-queue reference model (directed scenarios, then random traffic).
module tb_ram_kex_pingpong;
    import ram_kex_pingpong_pkg::*;

    localparam int DEPTH = KEX_N_ELEM;
    localparam int AW    = KEX_ADDR_W;
    localparam int DW    = KEX_DATA_W;
    localparam int HN    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en, wr_last, rd_en, rd_done;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data;

    always #5 clk = ~clk;

    ram_kex_pingpong_if u_if1 ();
    ram_kex_pingpong_if u_if2 ();

    assign u_if1.wr_en   = wr_en;    assign u_if2.wr_en   = wr_en;
    assign u_if1.wr_addr = wr_addr;  assign u_if2.wr_addr = wr_addr;
    assign u_if1.wr_data = wr_data;  assign u_if2.wr_data = wr_data;
    assign u_if1.wr_last = wr_last;  assign u_if2.wr_last = wr_last;
    assign u_if1.rd_en   = rd_en;    assign u_if2.rd_en   = rd_en;
    assign u_if1.rd_addr = rd_addr;  assign u_if2.rd_addr = rd_addr;
    assign u_if1.rd_done = rd_done;  assign u_if2.rd_done = rd_done;

    ram_kex_pingpong #(.RD_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .io_kex(u_if1.slave));
    ram_kex_pingpong #(.RD_LAT(2)) u_dut2 (.clk(clk), .rst(rst), .io_kex(u_if2.slave));

    // Reference model: completed tiles queue in order of arrival; the front
    // tile is the one being read. Word value -1 means "not known".
    typedef struct { int w[DEPTH]; } tile_t;

    tile_t      tiles[$];
    tile_t      fill;
    logic [1:0] m_err;
    bit         h_acc [HN];
    int         h_data[HN];
    int         held_d[2];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_fill();
        for (int i = 0; i < DEPTH; i++) fill.w[i] = -1;
    endtask

    task automatic check_port(input int lat, input bit ev, input logic valid,
                              input logic [DW-1:0] data, input logic fr,
                              input logic ta, input logic [1:0] err);
        check($sformatf("L%0d_rd_valid@%0d", lat, cyc), valid, ev);
        if (held_d[lat-1] >= 0)
            check($sformatf("L%0d_rd_data@%0d", lat, cyc), data, held_d[lat-1]);
        check($sformatf("L%0d_fill_ready@%0d", lat, cyc), fr, tiles.size() != 2);
        check($sformatf("L%0d_tile_avail@%0d", lat, cyc), ta, tiles.size() != 0);
        check($sformatf("L%0d_err@%0d", lat, cyc), err, m_err);
    endtask

    // Apply the current inputs to the model, clock once, then compare.
    task automatic step();
        int cs;
        int slot;
        bit ev[2];
        cs   = tiles.size();
        slot = cyc % HN;
        h_acc[slot] = 1'b0;
        if (rst) begin
            tiles.delete();
            clear_fill();
            m_err = 2'b00;
            h_acc[(cyc + HN - 1) % HN] = 1'b0;
            held_d[0] = 0;
            held_d[1] = 0;
        end else begin
            if (rd_en) begin
                if (cs > 0 && int'(rd_addr) < DEPTH) begin
                    h_acc[slot]  = 1'b1;
                    h_data[slot] = tiles[0].w[rd_addr];
                end else begin
                    m_err[1] = 1'b1;
                end
            end
            if (wr_en) begin
                if (cs < 2 && int'(wr_addr) < DEPTH) begin
                    fill.w[wr_addr] = int'(wr_data);
                    if (wr_last) begin
                        tiles.push_back(fill);
                        clear_fill();
                    end
                end else begin
                    m_err[0] = 1'b1;
                end
            end
            if (rd_done && cs > 0) void'(tiles.pop_front());
        end
        @(posedge clk);
        #1;
        for (int l = 1; l <= 2; l++) begin
            int idx;
            idx = (cyc - l + 1 + HN) % HN;
            ev[l-1] = h_acc[idx];
            if (ev[l-1]) held_d[l-1] = h_data[idx];
        end
        check_port(1, ev[0], u_if1.rd_valid, u_if1.rd_data, u_if1.fill_ready, u_if1.tile_avail, u_if1.err);
        check_port(2, ev[1], u_if2.rd_valid, u_if2.rd_data, u_if2.fill_ready, u_if2.tile_avail, u_if2.err);
        cyc++;
    endtask

    task automatic idle();
        wr_en   = 1'b0;
        wr_last = 1'b0;
        rd_en   = 1'b0;
        rd_done = 1'b0;
    endtask

    task automatic wr(input int a, input int d, input bit last);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = DW'(d); wr_last = last;
        step();
        idle();
    endtask

    task automatic rd(input int a);
        rd_en = 1'b1; rd_addr = AW'(a);
        step();
        idle();
    endtask

    task automatic release_tile();
        rd_done = 1'b1;
        step();
        idle();
    endtask

    task automatic fill_tile(input int base);
        for (int i = 0; i < DEPTH; i++) wr(i, i + base, i == DEPTH - 1);
    endtask

    initial begin
        rst = 1'b1; wr_addr = '0; wr_data = '0; rd_addr = '0;
        idle();
        clear_fill();
        held_d[0] = -1;
        held_d[1] = -1;
        step();
        step();
        rst = 1'b0;
        check("t0_rd_data_l1", u_if1.rd_data, 0);
        check("t0_tile_avail", u_if1.tile_avail, 0);

        // Tile 0: addr i -> i
        fill_tile(0);
        check("t1_tile_avail", u_if1.tile_avail, 1);
        check("t1_fill_ready", u_if1.fill_ready, 1);

        // Read latency 1 and 2
        rd(5);
        check("t2_l1_valid", u_if1.rd_valid, 1);
        check("t2_l1_data", u_if1.rd_data, 5);
        check("t2_l2_not_yet", u_if2.rd_valid, 0);
        step();
        check("t2_l2_valid", u_if2.rd_valid, 1);
        check("t2_l2_data", u_if2.rd_data, 5);
        check("t2_l1_single", u_if1.rd_valid, 0);

        // Second tile, then an overflowing write
        fill_tile(100);
        check("t3_fill_ready", u_if1.fill_ready, 0);
        wr(0, 12'hABC, 1'b0);
        check("t3_err_l1", u_if1.err, 2'b01);
        check("t3_err_l2", u_if2.err, 2'b01);
        release_tile();
        rd(3);
        check("t3_l1_data", u_if1.rd_data, 103);
        step();
        check("t3_l2_data", u_if2.rd_data, 103);

        // Completion and release in the same cycle at one tile held
        for (int i = 0; i < DEPTH - 1; i++) wr(i, i + 200, 1'b0);
        wr_en = 1'b1; wr_addr = AW'(DEPTH - 1); wr_data = DW'(DEPTH - 1 + 200);
        wr_last = 1'b1; rd_done = 1'b1;
        step();
        idle();
        check("t4_tile_avail", u_if1.tile_avail, 1);
        check("t4_fill_ready", u_if1.fill_ready, 1);
        rd(7);
        check("t4_l1_data", u_if1.rd_data, 207);
        step();
        check("t4_l2_data", u_if2.rd_data, 207);

        // Rejected reads and writes
        rst = 1'b1; step(); rst = 1'b0;
        rd(0);
        check("t5_empty_valid", u_if1.rd_valid, 0);
        check("t5_empty_err", u_if1.err, 2'b10);
        fill_tile(50);
        rd(DEPTH);
        check("t5_oob_valid", u_if1.rd_valid, 0);
        step();
        check("t5_oob_valid_l2", u_if2.rd_valid, 0);
        wr(DEPTH, 1, 1'b0);
        check("t5_wr_oob_err", u_if2.err, 2'b11);

        // Reset in the middle of a fill with reads in flight
        wr(0, 77, 1'b0);
        wr_en = 1'b1; wr_addr = AW'(1); wr_data = DW'(78);
        rd_en = 1'b1; rd_addr = AW'(4);
        step();
        check("t6_l1_data_pre", u_if1.rd_data, 54);
        rst = 1'b1; rd_addr = AW'(5);
        step();
        idle();
        rst = 1'b0;
        check("t6_l1_valid", u_if1.rd_valid, 0);
        check("t6_l2_valid", u_if2.rd_valid, 0);
        check("t6_tile_avail", u_if2.tile_avail, 0);
        check("t6_err", u_if2.err, 2'b00);
        check("t6_l2_data", u_if2.rd_data, 0);

`ifdef KRAM_PARITY_EN
        fill_tile(10);
        u_dut1.u_bank0.r_mem[2][DW] = ~u_dut1.u_bank0.r_mem[2][DW];
        u_dut2.u_bank0.r_mem[2][DW] = ~u_dut2.u_bank0.r_mem[2][DW];
        rd(2);
        check("par_l1", u_if1.err_parity, 1);
        check("par_l2_not_yet", u_if2.err_parity, 0);
        step();
        check("par_l2", u_if2.err_parity, 1);
        rst = 1'b1; step(); rst = 1'b0;
        check("par_reset", u_if1.err_parity, 0);
`endif

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            rst     = ($urandom_range(0, 249) == 0);
            wr_en   = ($urandom_range(0, 2) != 0);
            wr_addr = AW'($urandom_range(0, DEPTH + 1));
            wr_data = DW'($urandom);
            wr_last = ($urandom_range(0, 19) == 0);
            rd_en   = ($urandom_range(0, 1) != 0);
            rd_addr = AW'($urandom_range(0, DEPTH + 1));
            rd_done = ($urandom_range(0, 14) == 0);
            step();
        end
        idle();
        rst = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
